// File: rtl/ram_arbiter.sv
// DRAM sequencer/arbiter: CPU, video and sound fetches plus periodic refresh.
// Ports: CLK/RES, RAMCS/ASActive/nWE (CPU), VidReq/SndReq (DMA),
//   nRAS/nCAS/RAMnWE/RowSel/AddrSrc (DRAM), CPUDone/VidAck/SndAck, RefOverflow.
module ram_arbiter #(
  parameter int REFRESH_DIV = 250,
  parameter int CAS_CYC     = 2,
  parameter int PRE_CYC     = 2,
  parameter int REF_RAS_CYC = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       RAMCS,
  input  logic       ASActive,
  input  logic       nWE,
  input  logic       VidReq,
  input  logic       SndReq,
  output logic       nRAS,
  output logic       nCAS,
  output logic       RAMnWE,
  output logic       RowSel,
  output logic [1:0] AddrSrc,
  output logic       CPUDone,
  output logic       VidAck,
  output logic       SndAck,
  output logic       RefOverflow
);

  localparam int CW = 8;
  localparam int TW = $clog2(REFRESH_DIV + 1);
  localparam logic [CW-1:0] CAS_LAST = CW'(CAS_CYC - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] RRAS_LAST = CW'(REF_RAS_CYC - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, RAS, COL, CAS, RCAS, RRAS, PRE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          served_q, served_d;
  logic          nras_q, nras_d;
  logic          ncas_q, ncas_d;
  logic          we_q, we_d;
  logic          row_q, row_d;
  logic [1:0]    src_q, src_d;
  logic          done_q, done_d;
  logic          vack_q, vack_d;
  logic          sack_q, sack_d;
  logic          cpu_req, ref_grant, wrap, last_cas;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    we_d      = we_q;
    ref_grant = 1'b0;
    cpu_req   = RAMCS & ASActive & ~served_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 2'd0) begin
          ref_grant = 1'b1;
          state_d   = RCAS;
        end else if (SndReq) begin
          state_d = RAS;
          src_d   = 2'b10;
          we_d    = 1'b1;
        end else if (VidReq) begin
          state_d = RAS;
          src_d   = 2'b01;
          we_d    = 1'b1;
        end else if (cpu_req) begin
          state_d = RAS;
          src_d   = 2'b00;
          we_d    = nWE;
        end
      end
      RAS: state_d = COL;
      COL: begin
        state_d = CAS;
        cnt_d   = '0;
      end
      CAS: begin
        if (cnt_q == CAS_LAST) begin
          state_d = PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RCAS: begin
        state_d = RRAS;
        cnt_d   = '0;
      end
      RRAS: begin
        if (cnt_q == RRAS_LAST) begin
          state_d = PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == PRE) we_d = 1'b1;

    // Outputs are decoded from the next state so they appear with it.
    nras_d = ~((state_d == RAS) | (state_d == COL) |
               (state_d == CAS) | (state_d == RRAS));
    ncas_d = ~((state_d == CAS) | (state_d == RCAS) |
               (state_d == RRAS));
    row_d  = ~((state_d == COL) | (state_d == CAS));

    last_cas = (state_d == CAS) && (cnt_d == CAS_LAST);
    done_d   = last_cas && (src_q == 2'b00);
    vack_d   = last_cas && (src_q == 2'b01);
    sack_d   = last_cas && (src_q == 2'b10);

    // Blocks re-granting the same CPU bus cycle until the strobe drops.
    if (!ASActive) served_d = 1'b0;
    else if (done_d) served_d = 1'b1;
    else served_d = served_q;

    wrap    = (timer_q == TMR_LAST);
    timer_d = wrap ? '0 : timer_q + 1'b1;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (wrap && pend_q == 2'd3) ovf_d = 1'b1;
    // A wrap and a grant in the same cycle cancel out.
    if (wrap && !ref_grant && pend_q != 2'd3) pend_d = pend_q + 1'b1;
    if (ref_grant && !wrap) pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      served_q <= 1'b0;
      nras_q   <= 1'b1;
      ncas_q   <= 1'b1;
      we_q     <= 1'b1;
      row_q    <= 1'b1;
      src_q    <= 2'b00;
      done_q   <= 1'b0;
      vack_q   <= 1'b0;
      sack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      served_q <= served_d;
      nras_q   <= nras_d;
      ncas_q   <= ncas_d;
      we_q     <= we_d;
      row_q    <= row_d;
      src_q    <= src_d;
      done_q   <= done_d;
      vack_q   <= vack_d;
      sack_q   <= sack_d;
    end
  end

  assign nRAS        = nras_q;
  assign nCAS        = ncas_q;
  assign RAMnWE      = we_q;
  assign RowSel      = row_q;
  assign AddrSrc     = src_q;
  assign CPUDone     = done_q;
  assign VidAck      = vack_q;
  assign SndAck      = sack_q;
  assign RefOverflow = ovf_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus multi-cycle sequences.
module tb_ram_arbiter;

  logic CLK, RES, ORES;
  logic RAMCS, ASActive, nWE, VidReq, SndReq;
  logic nRAS, nCAS, RAMnWE, RowSel, CPUDone, VidAck, SndAck, RefOverflow;
  logic [1:0] AddrSrc;
  logic zero;
  logic o_nras, o_ncas, o_we, o_row, o_done, o_vack, o_sack, o_ovf;
  logic [1:0] o_src;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter dut (
    .CLK(CLK), .RES(RES), .RAMCS(RAMCS), .ASActive(ASActive),
    .nWE(nWE), .VidReq(VidReq), .SndReq(SndReq),
    .nRAS(nRAS), .nCAS(nCAS), .RAMnWE(RAMnWE), .RowSel(RowSel),
    .AddrSrc(AddrSrc), .CPUDone(CPUDone), .VidAck(VidAck),
    .SndAck(SndAck), .RefOverflow(RefOverflow)
  );

  // Short refresh period so refresh demand outruns service.
  ram_arbiter #(.REFRESH_DIV(4)) u_ovf (
    .CLK(CLK), .RES(ORES), .RAMCS(zero), .ASActive(zero),
    .nWE(zero), .VidReq(zero), .SndReq(zero),
    .nRAS(o_nras), .nCAS(o_ncas), .RAMnWE(o_we), .RowSel(o_row),
    .AddrSrc(o_src), .CPUDone(o_done), .VidAck(o_vack),
    .SndAck(o_sack), .RefOverflow(o_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic cs, as, wn, vid, snd;
    logic e_nras, e_ncas, e_row, e_we;
    logic [1:0] e_src;
    logic e_done;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(logic [4:0] in, logic [3:0] o,
                              logic [1:0] s, logic d);
    vec_t v;
    {v.cs, v.as, v.wn, v.vid, v.snd} = in;
    {v.e_nras, v.e_ncas, v.e_row, v.e_we} = o;
    v.e_src  = s;
    v.e_done = d;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    {RAMCS, ASActive, nWE, VidReq, SndReq} = 5'b00100;
    step();
    step();
    RES = 1'b0;
  endtask

  logic [8:0] act9, exp9;
  int sc, vc, cc, s_at, v_at, c_at, multi, bad, seen_ras, seen_cas;
  logic [4:0] rs [10];

  initial begin
    zero = 1'b0;
    ORES = 1'b1;
    RES  = 1'b1;
    {RAMCS, ASActive, nWE, VidReq, SndReq} = 5'b00100;
    #3;
    chk("reset_out",
        {nRAS, nCAS, RowSel, RAMnWE, AddrSrc, CPUDone, VidAck, SndAck,
         RefOverflow}, 10'b1111_00_0000);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {nRAS, nCAS, RowSel, CPUDone, VidAck, SndAck}, 6'b111000);
    end

    // in: cs as wn vid snd ; out: nras ncas row we
    for (int i = 0; i < 25; i++) vt[i] = mk(5'b11100, 4'b1111, 2'b00, 1'b0);
    vt[0]  = mk(5'b11100, 4'b0111, 2'b00, 1'b0);
    vt[1]  = mk(5'b11100, 4'b0101, 2'b00, 1'b0);
    vt[2]  = mk(5'b11100, 4'b0001, 2'b00, 1'b0);
    vt[3]  = mk(5'b11100, 4'b0001, 2'b00, 1'b1);
    vt[16] = mk(5'b10100, 4'b1111, 2'b00, 1'b0);
    vt[17] = mk(5'b11000, 4'b0110, 2'b00, 1'b0);
    vt[18] = mk(5'b11000, 4'b0100, 2'b00, 1'b0);
    vt[19] = mk(5'b11000, 4'b0000, 2'b00, 1'b0);
    vt[20] = mk(5'b11000, 4'b0000, 2'b00, 1'b1);
    vt[21] = mk(5'b11000, 4'b1111, 2'b00, 1'b0);
    vt[22] = mk(5'b11000, 4'b1111, 2'b00, 1'b0);
    vt[23] = mk(5'b11000, 4'b1111, 2'b00, 1'b0);
    vt[24] = mk(5'b10000, 4'b1111, 2'b00, 1'b0);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      {RAMCS, ASActive, nWE, VidReq, SndReq} =
        {vt[i].cs, vt[i].as, vt[i].wn, vt[i].vid, vt[i].snd};
      step();
      act9 = {nRAS, nCAS, RowSel, RAMnWE, AddrSrc, CPUDone, VidAck, SndAck};
      exp9 = {vt[i].e_nras, vt[i].e_ncas, vt[i].e_row, vt[i].e_we,
              vt[i].e_src, vt[i].e_done, 2'b00};
      chk($sformatf("vec%0d", i), act9, exp9);
    end

    // All three requesters at once.
    do_reset();
    {RAMCS, ASActive, nWE, VidReq, SndReq} = 5'b11111;
    sc = 0; vc = 0; cc = 0; s_at = -1; v_at = -1; c_at = -1; multi = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if ((32'(CPUDone) + 32'(VidAck) + 32'(SndAck)) > 1) multi++;
      if (SndAck) begin
        sc++; s_at = c;
        chk("snd_src", AddrSrc, 2'b10);
        SndReq = 1'b0;
      end
      if (VidAck) begin
        vc++; v_at = c;
        chk("vid_src", AddrSrc, 2'b01);
        VidReq = 1'b0;
      end
      if (CPUDone) begin
        cc++; c_at = c;
        chk("cpu_src", AddrSrc, 2'b00);
      end
    end
    chk("snd_at", s_at, 3);
    chk("vid_at", v_at, 10);
    chk("cpu_at", c_at, 17);
    chk("ack_counts", {sc[7:0], vc[7:0], cc[7:0]}, 24'h010101);
    chk("one_pulse", multi, 0);

    // Refresh pending on the same IDLE cycle as a sound request.
    do_reset();
    rs[0] = 5'b10000; rs[1] = 5'b00000; rs[2] = 5'b00000;
    rs[3] = 5'b11000; rs[4] = 5'b11000; rs[5] = 5'b11000;
    rs[6] = 5'b01010; rs[7] = 5'b01010; rs[8] = 5'b00010;
    rs[9] = 5'b00110;
    repeat (250) step();
    chk("pre_ref_idle", {nRAS, nCAS}, 2'b11);
    SndReq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("ref%0d", i), {nRAS, nCAS, SndAck, AddrSrc}, rs[i]);
      if (SndAck) SndReq = 1'b0;
    end

    // Reset in the middle of CAS.
    do_reset();
    {RAMCS, ASActive, nWE} = 3'b111;
    step(); step(); step();
    chk("mid_cas", {nRAS, nCAS}, 2'b00);
    #2 RES = 1'b1;
    #1 chk("async_rst", {nRAS, nCAS, RowSel}, 3'b111);
    {RAMCS, ASActive} = 2'b00;
    step();
    RES = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (CPUDone || !nRAS) bad++;
    end
    chk("no_done_after_rst", bad, 0);

    // Refresh backlog overflow on the short-period instance.
    chk("ovf_rst", o_ovf, 1'b0);
    ORES = 1'b0;
    step();
    chk("ovf_start", o_ovf, 1'b0);
    bad = 0; seen_ras = 0; seen_cas = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!o_nras) seen_ras++;
      if (!o_ncas) seen_cas++;
      if (o_done || o_vack || o_sack || o_src != 2'b00 || !o_we || !o_row)
        bad++;
    end
    chk("ovf_set", o_ovf, 1'b1);
    chk("ovf_refresh_seen", {seen_ras > 0, seen_cas > 0}, 2'b11);
    chk("ovf_no_acks", bad, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!o_ovf) bad++;
    end
    chk("ovf_sticky", bad, 0);
    #2 ORES = 1'b1;
    #1 chk("ovf_clear", o_ovf, 1'b0);
    step();
    ORES = 1'b0;
    step();
    chk("ovf_after_rst", o_ovf, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
